jtcps1_gfx_arb: RTL and testbench
=================================

// Module: jtcps1_gfx_arb
// PURPOSE
//  Shares one graphics-ROM SDRAM read port between the scroll engine (rom1) and the object engine (rom0).
//  Sits between the video block's two GFX ROM interfaces and the single SDRAM slot.
//  Grants one outstanding read at a time. Latches returned data per requester.
//  Keeps each requester's ok asserted while its address is unchanged.
// PARAMETERS
//  AW        20   requester word-address width (rom*_addr)
//  DW        32   data width
//  OBJ_FIRST 1    on a same-cycle tie at reset/first grant, 1 = rom0 (obj) wins, 0 = rom1
// PORTS
//  clk        in   1    system clock
//  rst        in   1    synchronous, active-high reset
//  rom0_cs    in   1    obj requester read strobe, held until rom0_ok
//  rom0_addr  in   AW   obj word address
//  rom0_half  in   1    obj half select
//  rom0_data  out  DW   obj read data
//  rom0_ok    out  1    obj data valid for current addr/half
//  rom1_cs    in   1    scroll requester read strobe
//  rom1_addr  in   AW   scroll word address
//  rom1_half  in   1    scroll half select
//  rom1_data  out  DW   scroll read data
//  rom1_ok    out  1    scroll data valid for current addr/half
//  mem_cs     out  1    SDRAM read request
//  mem_addr   out  AW+1 {addr,half} of granted requester
//  mem_data   in   DW   SDRAM read data, valid with mem_ok
//  mem_ok     in   1    one-cycle-or-longer completion strobe
//  busy       out  1    high while state != IDLE (debug/status)
// BEHAVIOUR
//  - Reset: mem_cs=0, mem_addr=0, rom*_ok=0, rom*_data=0, busy=0, state=IDLE, last=~OBJ_FIRST, both tags invalid.
//  - Pending(n): rom_n_cs=1 and not (tag_n valid and tag_n=={rom_n_addr,rom_n_half}).
//  - FSM IDLE: if any pending, grant = the pending one. If both are pending, grant the one != last (round robin).
//    Latch {addr,half} into mem_addr, mem_cs<=1, go to WAIT.
//  - FSM WAIT: hold mem_cs/mem_addr stable. On mem_ok: rom_g_data<=mem_data, tag_g<=mem_addr, tag_g valid,
//    mem_cs<=0, last<=g, go to IDLE.
//  - No new grant is issued on the cycle mem_ok is seen; min 2 cycles between grants.
//  - rom_n_ok is combinational: rom_n_cs & tag_n valid & tag match. It drops the same cycle the address/half
//    changes or cs drops.
//  - Latency: idle arbiter, cs rises in cycle 0 -> mem_cs=1 in cycle 1; mem_ok in cycle k -> rom_ok=1 in k+1.
//  - Requester changes address while its read is in WAIT: the transaction completes with the old address.
//    The tag then mismatches, so ok stays 0 and a new request follows. mem_addr never changes mid-WAIT.
//  - A requester whose cs drops during WAIT: data is still latched into tag/data; no ok is shown.
//  - mem_ok while IDLE: ignored.
//  - Sync reset mid-WAIT: return to IDLE, mem_cs=0 next cycle. A late mem_ok afterwards is ignored.
//  - rom_data is updated only on its own completion. Data is held across the other requester's reads.
// CONFIGURATION
//  JTCPS1_GFXARB_PRIO_EN defined: fixed priority, rom0 (obj) always wins a tie. last/round robin is unused.
//  Not defined: round robin as above.
//  OBJ_FIRST applies only to the first tie after reset.
// TESTING
//  - Single read: rom0_cs=1,addr=20'h12345,half=1; mem_ok 3 cycles after mem_cs with mem_data=32'hDEADBEEF
//    -> mem_addr=21'h2468B, rom0_data=DEADBEEF, rom0_ok=1 one cycle after mem_ok, and it stays 1.
//  - Tie: both cs rise the same cycle after reset, OBJ_FIRST=1 -> rom0 granted first, rom1 granted
//    two cycles after rom0's mem_ok. Repeat with both pending -> grants alternate 0,1,0,1.
//  - Address hop during WAIT: rom1 changes addr 5->6 before mem_ok -> rom1_ok stays 0, and a second
//    mem_cs is issued with addr 6.
//  - Hit reuse: rom0 rereads the same addr/half after rom1 serviced -> rom0_ok=1 with no mem_cs.
//  - Reset mid-WAIT, then a stray mem_ok -> mem_cs=0, both ok=0, no tag written.
//  - With JTCPS1_GFXARB_PRIO_EN: both continuously pending at new addresses -> rom0 wins every tie.

Source files
------------

// File: rtl/jtcps1_gfx_arb.sv
// Graphics ROM read-port arbiter: shares one SDRAM slot between obj (rom0) and scroll (rom1).
// Optional macro JTCPS1_GFXARB_PRIO_EN: fixed priority, obj always wins a tie.
module jtcps1_gfx_arb #(
    parameter int AW        = 20,
    parameter int DW        = 32,
    parameter bit OBJ_FIRST = 1'b1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          rom0_cs,
    input  logic [AW-1:0] rom0_addr,
    input  logic          rom0_half,
    output logic [DW-1:0] rom0_data,
    output logic          rom0_ok,
    input  logic          rom1_cs,
    input  logic [AW-1:0] rom1_addr,
    input  logic          rom1_half,
    output logic [DW-1:0] rom1_data,
    output logic          rom1_ok,
    output logic          mem_cs,
    output logic [AW:0]   mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          mem_ok,
    output logic          busy
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nx;
    logic [AW:0] req0, req1;
    logic [AW:0] tag0, tag1;
    logic        tag0_v, tag1_v;
    logic        hit0, hit1;
    logic        pend0, pend1;
    logic        gnt_obj;
    logic        issue, pick_obj, done;

    assign req0  = {rom0_addr, rom0_half};
    assign req1  = {rom1_addr, rom1_half};
    assign hit0  = tag0_v && (tag0 == req0);
    assign hit1  = tag1_v && (tag1 == req1);
    assign pend0 = rom0_cs && !hit0;
    assign pend1 = rom1_cs && !hit1;

    assign rom0_ok = rom0_cs && hit0;
    assign rom1_ok = rom1_cs && hit1;
    assign busy    = (state != IDLE);

`ifndef JTCPS1_GFXARB_PRIO_EN
    logic last_obj;

    // round-robin memory: set when obj was the last requester served
    always_ff @(posedge clk) begin
        if (rst)       last_obj <= !OBJ_FIRST;
        else if (done) last_obj <= gnt_obj;
    end
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and grant decision
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        pick_obj = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    issue    = 1'b1;
                    state_nx = WAIT;
                    if (pend0 && pend1) begin
`ifdef JTCPS1_GFXARB_PRIO_EN
                        pick_obj = 1'b1;
`else
                        pick_obj = !last_obj;
`endif
                    end else begin
                        pick_obj = pend0;
                    end
                end
            end
            WAIT: begin
                if (mem_ok) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // memory request, per-requester data and tag capture
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_cs    <= 1'b0;
            mem_addr  <= '0;
            gnt_obj   <= 1'b0;
            rom0_data <= '0;
            rom1_data <= '0;
            tag0      <= '0;
            tag1      <= '0;
            tag0_v    <= 1'b0;
            tag1_v    <= 1'b0;
        end else begin
            if (issue) begin
                mem_cs   <= 1'b1;
                mem_addr <= pick_obj ? req0 : req1;
                gnt_obj  <= pick_obj;
            end
            if (done) begin
                mem_cs <= 1'b0;
                if (gnt_obj) begin
                    rom0_data <= mem_data;
                    tag0      <= mem_addr;
                    tag0_v    <= 1'b1;
                end else begin
                    rom1_data <= mem_data;
                    tag1      <= mem_addr;
                    tag1_v    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtcps1_gfx_arb.sv
// Self-checking bench for jtcps1_gfx_arb: scoreboarded grants,
// latency, tie/round-robin, address hop, hit reuse and reset corners.
`timescale 1ns/1ps
module tb_jtcps1_gfx_arb;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rom0_cs = 1'b0, rom0_half = 1'b0;
    logic [AW-1:0] rom0_addr = '0;
    logic [DW-1:0] rom0_data;
    logic          rom0_ok;
    logic          rom1_cs = 1'b0, rom1_half = 1'b0;
    logic [AW-1:0] rom1_addr = '0;
    logic [DW-1:0] rom1_data;
    logic          rom1_ok;
    logic          mem_cs;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ok = 1'b0;
    logic          busy;

    always #10 clk = ~clk;

    jtcps1_gfx_arb #(.AW(AW), .DW(DW), .OBJ_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .rom0_cs(rom0_cs), .rom0_addr(rom0_addr), .rom0_half(rom0_half),
        .rom0_data(rom0_data), .rom0_ok(rom0_ok),
        .rom1_cs(rom1_cs), .rom1_addr(rom1_addr), .rom1_half(rom1_half),
        .rom1_data(rom1_data), .rom1_ok(rom1_ok),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ok(mem_ok), .busy(busy)
    );

    typedef struct {
        bit            sel;
        bit            cs;
        logic [AW-1:0] addr;
        bit            half;
        bit            exp_ok;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [AW:0] exp_q[$];
    int          rise_cyc[$];
    int          okc[$];
    int          lat = 2;
    bit          mem_auto = 1'b1;
    bit          fix_en = 1'b0;
    logic [31:0] fix_val = '0;
    int          cnt = 0;
    logic        prev_cs = 1'b0;
    logic [AW:0] cur_addr = '0;

    function automatic logic [31:0] fdat(input logic [AW:0] a);
        return {a[10:0] ^ 11'h5A5, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/none expected event", name);
    endtask

    // one clock: SDRAM model and grant scoreboard
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_auto && mem_ok) mem_ok = 1'b0;
        if (mem_cs && !prev_cs) begin
            rise_cyc.push_back(cyc);
            cur_addr = mem_addr;
            cnt = 0;
            if (exp_q.size() == 0) fail("unexpected_grant");
            else chk("grant_addr", mem_addr, exp_q.pop_front());
        end else if (mem_cs && mem_auto && !mem_ok) begin
            chk("hold_addr", mem_addr, cur_addr);
            cnt++;
            if (cnt >= lat) begin
                mem_ok = 1'b1;
                mem_data = fix_en ? fix_val : fdat(mem_addr);
                okc.push_back(cyc);
            end
        end
        prev_cs = mem_cs;
    endtask

    task automatic wait_ok(input bit sel, input int max, input string name);
        for (int n = 0; n < max && !(sel ? rom1_ok : rom0_ok); n++) tick();
        if (!(sel ? rom1_ok : rom0_ok)) fail(name);
    endtask

    vec_t tbl[8];
    localparam logic [AW-1:0] X = 20'h00777;
    localparam logic [AW-1:0] Y = 20'h00888;

    initial begin
        int c0, n0, okn, g, d0, d1;
        bit early;
        tbl[0] = '{1'b0, 1'b1, X,         1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b0, X,         1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, X + 20'd1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, X,         1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, Y,         1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, Y,         1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, Y,         1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, Y ^ 20'd1, 1'b0, 1'b0};

        // reset state
        tick(); tick();
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rom0_data", rom0_data, 0);
        chk("rst_rom1_data", rom1_data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // single read, mem_ok three cycles after mem_cs
        lat = 3; fix_en = 1'b1; fix_val = 32'hDEADBEEF;
        exp_q.push_back(21'h2468B);
        rom0_addr = 20'h12345; rom0_half = 1'b1; rom0_cs = 1'b1;
        c0 = cyc;
        tick();
        chk("t1_mem_cs", mem_cs, 1);
        chk("t1_busy", busy, 1);
        chk("t1_mem_addr", mem_addr, 21'h2468B);
        chk("t1_ok_early", rom0_ok, 0);
        wait_ok(1'b0, 20, "t1_wait_ok");
        if (okc.size() > 0) begin
            chk("t1_memok_cyc", okc[okc.size()-1], c0 + 4);
            chk("t1_ok_cyc", cyc, okc[okc.size()-1] + 1);
        end else fail("t1_no_memok");
        chk("t1_data", rom0_data, 32'hDEADBEEF);
        repeat (3) tick();
        chk("t1_ok_held", rom0_ok, 1);
        chk("t1_idle_cs", mem_cs, 0);
        chk("t1_idle_busy", busy, 0);
        fix_en = 1'b0; rom0_cs = 1'b0;

        // tie after reset: obj first, scroll two cycles after obj mem_ok
        rst = 1'b1; tick(); rst = 1'b0;
        lat = 2;
        exp_q.push_back({20'h00100, 1'b0});
        exp_q.push_back({20'h00200, 1'b1});
        n0 = rise_cyc.size(); okn = okc.size();
        rom0_addr = 20'h00100; rom0_half = 1'b0; rom0_cs = 1'b1;
        rom1_addr = 20'h00200; rom1_half = 1'b1; rom1_cs = 1'b1;
        for (int n = 0; n < 40 && !(rom0_ok && rom1_ok); n++) tick();
        if (!(rom0_ok && rom1_ok)) fail("t2_wait_both");
        if (rise_cyc.size() >= n0 + 2 && okc.size() >= okn + 1)
            chk("t2_gap", rise_cyc[n0+1] - okc[okn], 2);
        else fail("t2_gap_events");
        chk("t2_d0", rom0_data, fdat({20'h00100, 1'b0}));
        chk("t2_d1", rom1_data, fdat({20'h00201 - 20'd1, 1'b1}));

        // both continuously pending at new addresses
`ifdef JTCPS1_GFXARB_PRIO_EN
        for (int i = 0; i < 3; i++) exp_q.push_back({20'h00300 + 20'(i), 1'b0});
        for (int i = 0; i < 3; i++) exp_q.push_back({20'h00400 + 20'(i), 1'b0});
`else
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({20'h00300 + 20'(i), 1'b0});
            exp_q.push_back({20'h00400 + 20'(i), 1'b0});
        end
`endif
        d0 = 0; d1 = 0;
        rom0_addr = 20'h00300; rom0_half = 1'b0;
        rom1_addr = 20'h00400; rom1_half = 1'b0;
        for (int n = 0; n < 300 && (rom0_cs || rom1_cs); n++) begin
            tick();
            if (rom0_cs && rom0_ok) begin
                chk("t2_rr_d0", rom0_data, fdat({rom0_addr, 1'b0}));
                d0++;
                if (d0 == 3) rom0_cs = 1'b0; else rom0_addr++;
            end
            if (rom1_cs && rom1_ok) begin
                chk("t2_rr_d1", rom1_data, fdat({rom1_addr, 1'b0}));
                d1++;
                if (d1 == 3) rom1_cs = 1'b0; else rom1_addr++;
            end
        end
        chk("t2_rr_n0", d0, 3);
        chk("t2_rr_n1", d1, 3);
        tick();

        // scroll hops address 5 -> 6 during WAIT
        lat = 4;
        exp_q.push_back({20'h5, 1'b0});
        g = rise_cyc.size();
        rom1_addr = 20'h5; rom1_half = 1'b0; rom1_cs = 1'b1;
        tick(); tick(); tick();
        rom1_addr = 20'h6;
        exp_q.push_back({20'h6, 1'b0});
        early = 1'b0;
        for (int n = 0; n < 40 && !rom1_ok; n++) begin
            tick();
            if (rom1_ok && rise_cyc.size() < g + 2) early = 1'b1;
        end
        if (!rom1_ok) fail("t3_wait_ok");
        chk("t3_no_early_ok", early, 0);
        chk("t3_grants", rise_cyc.size(), g + 2);
        chk("t3_data", rom1_data, fdat({20'h6, 1'b0}));
        rom1_cs = 1'b0;

        // hit reuse after the other requester is serviced
        lat = 2;
        exp_q.push_back({X, 1'b1});
        rom0_addr = X; rom0_half = 1'b1; rom0_cs = 1'b1;
        wait_ok(1'b0, 20, "t4_wait0");
        rom0_cs = 1'b0;
        exp_q.push_back({Y, 1'b0});
        rom1_addr = Y; rom1_half = 1'b0; rom1_cs = 1'b1;
        wait_ok(1'b1, 20, "t4_wait1");
        rom1_cs = 1'b0;
        tick();
        g = rise_cyc.size();
        rom0_cs = 1'b1;
        #1;
        chk("t4_hit_ok", rom0_ok, 1);
        chk("t4_hit_data", rom0_data, fdat({X, 1'b1}));
        repeat (4) tick();
        chk("t4_no_grant", rise_cyc.size(), g);
        chk("t4_ok_held", rom0_ok, 1);
        rom0_cs = 1'b0;
        tick();

        // ok decode table, no clock edge in between
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].sel) begin
                rom1_cs = tbl[i].cs; rom1_addr = tbl[i].addr; rom1_half = tbl[i].half;
            end else begin
                rom0_cs = tbl[i].cs; rom0_addr = tbl[i].addr; rom0_half = tbl[i].half;
            end
            #1;
            chk($sformatf("tbl_ok_%0d", i), tbl[i].sel ? rom1_ok : rom0_ok, tbl[i].exp_ok);
            rom0_cs = 1'b0; rom1_cs = 1'b0;
        end
        repeat (2) tick();
        chk("tbl_no_grant", rise_cyc.size(), g);

        // reset mid-WAIT, then a stray mem_ok
        lat = 50;
        exp_q.push_back({20'h00999, 1'b0});
        rom0_addr = 20'h00999; rom0_half = 1'b0; rom0_cs = 1'b1;
        tick(); tick();
        chk("t5_in_wait", busy, 1);
        rst = 1'b1; rom0_cs = 1'b0;
        rom1_addr = Y; rom1_half = 1'b0; rom1_cs = 1'b1;
        tick();
        chk("t5_rst_cs", mem_cs, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ok1", rom1_ok, 0);
        rom1_cs = 1'b0; rst = 1'b0;
        tick();
        mem_auto = 1'b0; mem_ok = 1'b1; mem_data = 32'hBAD0BAD0;
        tick();
        mem_ok = 1'b0;
        chk("t5_stray_cs", mem_cs, 0);
        chk("t5_stray_busy", busy, 0);
        tick();
        chk("t5_d0", rom0_data, 0);
        chk("t5_d1", rom1_data, 0);
        rom1_addr = '0; rom1_half = 1'b0; rom1_cs = 1'b1;
        #1;
        chk("t5_no_tag", rom1_ok, 0);
        mem_auto = 1'b1; lat = 2;
        exp_q.push_back({20'h0, 1'b0});
        wait_ok(1'b1, 20, "t5_wait_ok");
        chk("t5_data", rom1_data, fdat(21'h0));
        rom1_cs = 1'b0;
        tick();

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
